// File: rtl/counter_timer_ctrl_if.sv
// Handshake bundle between the config side, the counter datapath and counter_timer_ctrl.
// The controller sits on the slave modport; the driving environment uses master.
interface counter_timer_ctrl_if #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned PRESC_WIDTH = 8
);
   logic                   start_i;
   logic                   stop_i;
   logic                   periodic_i;
   logic [WIDTH-1:0]       reload_i;
   logic [PRESC_WIDTH-1:0] presc_i;
   logic                   cnt_overflow_i;
   logic                   cnt_load_o;
   logic [WIDTH-1:0]       cnt_val_o;
   logic                   cnt_en_o;
   logic                   busy_o;
   logic                   done_o;

   modport master (
      output start_i, stop_i, periodic_i, reload_i, presc_i, cnt_overflow_i,
      input  cnt_load_o, cnt_val_o, cnt_en_o, busy_o, done_o
   );

   modport slave (
      input  start_i, stop_i, periodic_i, reload_i, presc_i, cnt_overflow_i,
      output cnt_load_o, cnt_val_o, cnt_en_o, busy_o, done_o
   );
endinterface

// File: rtl/counter_timer_ctrl.sv
// Sequencer for one counter: loads the reload value, paces increments with a prescaler,
// and turns the counter's sticky overflow into a one-cycle done pulse (one-shot or periodic).
module counter_timer_ctrl #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned PRESC_WIDTH = 8
) (
   input logic                clk,
   input logic                rst,
   counter_timer_ctrl_if.slave bus
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StLoad = 2'd1;
   localparam logic [1:0] StRun  = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   logic [1:0]             state_q, state_d;
   logic [WIDTH-1:0]       reload_q, reload_d;
   logic [PRESC_WIDTH-1:0] presc_q, presc_d;
   logic                   periodic_q, periodic_d;
   logic [PRESC_WIDTH-1:0] psc_q, psc_d;
   logic                   tick;

   assign tick = (psc_q == presc_q);

   always_comb begin
      state_d    = state_q;
      reload_d   = reload_q;
      presc_d    = presc_q;
      periodic_d = periodic_q;
      psc_d      = psc_q;
      case (state_q)
         StIdle: begin
            if (bus.start_i && !bus.stop_i) begin
               reload_d   = bus.reload_i;
               presc_d    = bus.presc_i;
               periodic_d = bus.periodic_i;
               state_d    = StLoad;
            end
         end
         StLoad: begin
            psc_d   = '0;
            state_d = StRun;
         end
         StRun: begin
            psc_d = tick ? '0 : psc_q + PRESC_WIDTH'(1);
            if (bus.cnt_overflow_i) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = periodic_q ? StLoad : StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      // Abort wins over everything, including a same-cycle start.
      if (bus.stop_i) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         reload_q   <= '0;
         presc_q    <= '0;
         periodic_q <= 1'b0;
         psc_q      <= '0;
      end else begin
         state_q    <= state_d;
         reload_q   <= reload_d;
         presc_q    <= presc_d;
         periodic_q <= periodic_d;
         psc_q      <= psc_d;
      end
   end

   assign bus.cnt_val_o  = reload_q;
   assign bus.cnt_load_o = (state_q == StLoad);
   assign bus.busy_o     = (state_q != StIdle);
   assign bus.done_o     = (state_q == StDone);
   // Gated by overflow so the counter can never step past its wrap point.
   assign bus.cnt_en_o   = (state_q == StRun) && tick && !bus.cnt_overflow_i;

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Directed bench for counter_timer_ctrl with a behavioural 4-bit counter attached.
module tb_counter_timer_ctrl;
   localparam int unsigned W  = 4;
   localparam int unsigned PW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   counter_timer_ctrl_if #(.WIDTH(W), .PRESC_WIDTH(PW)) bus ();

   counter_timer_ctrl #(.WIDTH(W), .PRESC_WIDTH(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Counter datapath model: load clears the sticky overflow, overflow set on wrap.
   logic [W-1:0] m_cnt = '0;
   logic         m_ovf = 1'b0;
   always_ff @(posedge clk) begin
      if (bus.cnt_load_o) begin
         m_cnt <= bus.cnt_val_o;
         m_ovf <= 1'b0;
      end else if (bus.cnt_en_o) begin
         m_cnt <= m_cnt + W'(1);
         if (m_cnt == '1) m_ovf <= 1'b1;
      end
   end
   assign bus.cnt_overflow_i = m_ovf;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [63:0]   m_load, m_en, m_done, m_busy;
   logic [PW-1:0] psc_log [64];
   logic [W-1:0]  val_last;

   task automatic setup(input logic [W-1:0] rl, input logic [PW-1:0] ps, input logic per);
      bus.reload_i   = rl;
      bus.presc_i    = ps;
      bus.periodic_i = per;
   endtask

   // Cycle 0 is the start cycle; bit c of each mask is the output during cycle c.
   task automatic capture(input int n, input int stop_at, input int restart_at,
                          input logic [W-1:0] alt_reload);
      m_load = '0;
      m_en   = '0;
      m_done = '0;
      m_busy = '0;
      for (int c = 0; c < n; c++) begin
         bus.start_i = (c == 0) || (c == restart_at);
         bus.stop_i  = (c == stop_at);
         if (c == restart_at) begin
            bus.reload_i   = alt_reload;
            bus.presc_i    = 8'd5;
            bus.periodic_i = 1'b1;
         end
         #1;
         m_load[c]  = bus.cnt_load_o;
         m_en[c]    = bus.cnt_en_o;
         m_done[c]  = bus.done_o;
         m_busy[c]  = bus.busy_o;
         psc_log[c] = dut.psc_q;
         val_last   = bus.cnt_val_o;
         @(posedge clk);
         #1;
      end
      bus.start_i = 1'b0;
      bus.stop_i  = 1'b0;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_en, last_en, n_en, min_gap, max_gap, done_at;
      bus.start_i = 1'b0;
      bus.stop_i  = 1'b0;
      setup(4'd0, 8'd0, 1'b0);

      // Reset state
      tick_n(3);
      rst = 1'b0;
      #1;
      check("rst_busy", 64'(bus.busy_o), 64'd0);
      check("rst_load", 64'(bus.cnt_load_o), 64'd0);
      check("rst_done", 64'(bus.done_o), 64'd0);
      check("rst_en", 64'(bus.cnt_en_o), 64'd0);
      check("rst_val", 64'(bus.cnt_val_o), 64'd0);
      tick_n(1);

      // 1: one-shot, reload=14, presc=0
      setup(4'd14, 8'd0, 1'b0);
      capture(10, -1, -1, 4'd0);
      check("t1_load", m_load, 64'h2);
      check("t1_en", m_en, 64'hC);
      check("t1_done", m_done, 64'h20);
      check("t1_busy", m_busy, 64'h3E);

      // 2: reload=15, presc=2
      setup(4'd15, 8'd2, 1'b0);
      capture(10, -1, -1, 4'd0);
      check("t2_en", m_en, 64'h10);
      check("t2_done", m_done, 64'h40);
      check("t2_busy", m_busy, 64'h7E);
      check("t2_psc", {32'd0, psc_log[2], psc_log[3], psc_log[4], psc_log[5]}, 64'h00010200);

      // 3: periodic, reload=14, presc=0, then stop
      setup(4'd14, 8'd0, 1'b1);
      capture(17, -1, -1, 4'd0);
      check("t3_load", m_load, 64'h10842);
      check("t3_done", m_done, 64'h8420);
      check("t3_en", m_en, 64'h318C);
      check("t3_busy", m_busy, 64'h1FFFE);
      bus.stop_i = 1'b1;
      tick_n(1);
      bus.stop_i = 1'b0;
      #1;
      check("t3_stopped", 64'(bus.busy_o), 64'd0);
      tick_n(1);

      // 4: stop at cycle 3 of test 1; then start together with stop
      setup(4'd14, 8'd0, 1'b0);
      capture(10, 3, -1, 4'd0);
      check("t4_busy", m_busy, 64'hE);
      check("t4_done", m_done, 64'h0);
      capture(4, 0, -1, 4'd0);
      check("t4_ss_load", m_load, 64'h0);
      check("t4_ss_busy", m_busy, 64'h0);

      // 5: start during RUN with new config is ignored
      setup(4'd14, 8'd0, 1'b0);
      capture(10, -1, 3, 4'd3);
      check("t5_load", m_load, 64'h2);
      check("t5_en", m_en, 64'hC);
      check("t5_done", m_done, 64'h20);
      check("t5_val", 64'(val_last), 64'd14);

      // 5b: rst while in RUN
      setup(4'd14, 8'd0, 1'b0);
      bus.start_i = 1'b1;
      tick_n(1);
      bus.start_i = 1'b0;
      tick_n(1);
      check("t5_in_run", 64'(bus.busy_o), 64'd1);
      rst = 1'b1;
      tick_n(1);
      rst = 1'b0;
      check("t5_rst_busy", 64'(bus.busy_o), 64'd0);
      check("t5_rst_load", 64'(bus.cnt_load_o), 64'd0);
      check("t5_rst_done", 64'(bus.done_o), 64'd0);
      check("t5_rst_en", 64'(bus.cnt_en_o), 64'd0);
      check("t5_rst_val", 64'(bus.cnt_val_o), 64'd0);
      tick_n(1);

      // 6: reload=0, presc=255
      setup(4'd0, 8'd255, 1'b0);
      first_en = -1;
      last_en  = -1;
      n_en     = 0;
      min_gap  = 1_000_000;
      max_gap  = 0;
      done_at  = -1;
      for (int c = 0; c < 4300 && done_at < 0; c++) begin
         bus.start_i = (c == 0);
         #1;
         if (bus.cnt_en_o) begin
            if (last_en >= 0) begin
               if (c - last_en < min_gap) min_gap = c - last_en;
               if (c - last_en > max_gap) max_gap = c - last_en;
            end
            if (first_en < 0) first_en = c;
            last_en = c;
            n_en++;
         end
         if (bus.done_o) done_at = c;
         @(posedge clk);
         #1;
      end
      bus.start_i = 1'b0;
      check("t6_n_en", 64'(n_en), 64'd16);
      check("t6_first_en", 64'(first_en), 64'd257);
      check("t6_min_gap", 64'(min_gap), 64'd256);
      check("t6_max_gap", 64'(max_gap), 64'd256);
      check("t6_done_at", 64'(done_at), 64'd4099);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
